// File: rtl/control_pkg.sv
// Shared constants for the multicycle control unit: state encoding, opcodes,
// branch condition codes and ALU flag bit positions.
package control_pkg;

    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StBranch = 3'd3;
    localparam logic [2:0] StLoad1  = 3'd4;
    localparam logic [2:0] StLoad2  = 3'd5;
    localparam logic [2:0] StStore  = 3'd6;
    localparam logic [2:0] StWait   = 3'd7;

    localparam logic [3:0] OP_BCOND = 4'hC;
    localparam logic [3:0] OP_JCOND = 4'h4;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;
    localparam logic [3:0] OP_WAIT  = 4'hF;
    localparam logic [3:0] OP_ADDI  = 4'h5;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4;
    localparam logic [3:0] COND_LS = 4'd5;
    localparam logic [3:0] COND_GT = 4'd6;
    localparam logic [3:0] COND_LE = 4'd7;
    localparam logic [3:0] COND_FS = 4'd8;
    localparam logic [3:0] COND_FC = 4'd9;
    localparam logic [3:0] COND_UC = 4'd14;

    // Flags vector is {N,Z,F,L,C}
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_L = 1;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 4;

endpackage

// File: rtl/cond_check.sv
// Branch condition evaluator: decides whether a 4-bit condition code holds
// for the saved ALU flags.
module cond_check
    import control_pkg::*;
(
    input  logic [4:0] flags,
    input  logic [3:0] cond,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = flags[FLAG_Z];
            COND_NE: taken = !flags[FLAG_Z];
            COND_CS: taken = flags[FLAG_C];
            COND_CC: taken = !flags[FLAG_C];
            COND_HI: taken = flags[FLAG_L];
            COND_LS: taken = !flags[FLAG_L];
            COND_GT: taken = flags[FLAG_N];
            COND_LE: taken = !flags[FLAG_N];
            COND_FS: taken = flags[FLAG_F];
            COND_FC: taken = !flags[FLAG_F];
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit: fetch into IR, decode, and sequence datapath controls.
// Timed WAIT instruction is built only when CONTROL_WAIT_EN is defined.
module control_fsm
    import control_pkg::*;
#(
    parameter int unsigned PC_WIDTH       = 15,
    parameter int unsigned WAIT_CYCLES    = 166666,
    parameter int unsigned WAIT_CNT_WIDTH = $clog2(WAIT_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         mem_rdata,
    input  logic                mem_ready,
    input  logic [4:0]          alu_flags,
    input  logic [PC_WIDTH-1:0] reg_b,
    output logic [PC_WIDTH-1:0] pc,
    output logic                mem_addr_sel,
    output logic                mem_we,
    output logic                reg_we,
    output logic                wb_sel,
    output logic                alu_op_sel,
    output logic [15:0]         alu_override,
    output logic [3:0]          reg_waddr,
    output logic [3:0]          reg_raddr_a,
    output logic [3:0]          reg_raddr_b,
    output logic [4:0]          saved_flags,
    output logic                busy_wait
);

    if (WAIT_CYCLES < 1 || WAIT_CNT_WIDTH < $clog2(WAIT_CYCLES + 1) || PC_WIDTH < 8)
    begin : g_param_check
        $error("control_fsm: invalid PC_WIDTH / WAIT_CYCLES / WAIT_CNT_WIDTH");
    end

    logic [2:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [4:0]          flags_q, flags_d;
    logic [3:0]          opcode;
    logic                taken;
    logic                exec_nop;
    logic [PC_WIDTH-1:0] pc_inc, pc_rel;

    assign opcode = ir_q[15:12];
    assign pc_inc = pc_q + PC_WIDTH'(1);
    assign pc_rel = pc_q + {{(PC_WIDTH - 8){ir_q[7]}}, ir_q[7:0]};

    cond_check u_cond_check (
        .flags (flags_q),
        .cond  (ir_q[11:8]),
        .taken (taken)
    );

`ifdef CONTROL_WAIT_EN
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                      wait_done;

    assign wait_done = (wait_cnt_q == WAIT_CNT_WIDTH'(WAIT_CYCLES - 1));
    assign exec_nop  = 1'b0;
`else
    // Without the timer, WAIT falls through EXEC as a NOP
    assign exec_nop  = (opcode == OP_WAIT);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
`ifdef CONTROL_WAIT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (opcode)
                    OP_BCOND, OP_JCOND: state_d = StBranch;
                    OP_LOAD:            state_d = StLoad1;
                    OP_STORE:           state_d = StStore;
`ifdef CONTROL_WAIT_EN
                    OP_WAIT:            state_d = StWait;
`endif
                    default:            state_d = StExec;
                endcase
            end
            StExec: begin
                if (!exec_nop) begin
                    flags_d = alu_flags;
                end
                pc_d    = pc_inc;
                state_d = StFetch;
            end
            StBranch: begin
                if (!taken) begin
                    pc_d = pc_inc;
                end else if (opcode == OP_JCOND) begin
                    pc_d = reg_b;
                end else begin
                    pc_d = pc_rel;
                end
                state_d = StFetch;
            end
            StLoad1: begin
                if (mem_ready) begin
                    state_d = StLoad2;
                end
            end
            StLoad2, StStore: begin
                pc_d    = pc_inc;
                state_d = StFetch;
            end
`ifdef CONTROL_WAIT_EN
            StWait: begin
                if (wait_done) begin
                    wait_cnt_d = '0;
                    pc_d       = pc_inc;
                    state_d    = StFetch;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_WIDTH'(1);
                end
            end
`endif
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
`ifdef CONTROL_WAIT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
`ifdef CONTROL_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    always_comb begin
        mem_addr_sel = 1'b1;
        mem_we       = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 1'b1;
        alu_op_sel   = 1'b1;
        alu_override = 16'h0000;
        busy_wait    = 1'b0;
        case (state_q)
            StExec: reg_we = !exec_nop;
            StLoad1: mem_addr_sel = 1'b0;
            StLoad2: begin
                mem_addr_sel = 1'b0;
                reg_we       = 1'b1;
                wb_sel       = 1'b0;
            end
            StStore: begin
                mem_addr_sel = 1'b0;
                mem_we       = 1'b1;
                alu_op_sel   = 1'b0;
                // ADDI #0 on reg_a makes the ALU forward the store data
                alu_override = {OP_ADDI, ir_q[11:8], 8'h00};
            end
`ifdef CONTROL_WAIT_EN
            StWait: busy_wait = 1'b1;
`endif
            default: ;
        endcase
    end

    assign pc          = pc_q;
    assign saved_flags = flags_q;
    assign reg_waddr   = ir_q[11:8];
    assign reg_raddr_a = ir_q[11:8];
    assign reg_raddr_b = ir_q[3:0];

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: table of single-instruction vectors plus
// hand-written reset sequences (mid-WAIT and stalled LOAD1).
module tb_control_fsm;

    localparam int PW = 15;
    localparam int WC = 4;
`ifdef CONTROL_WAIT_EN
    localparam int WAIT_CYC  = 2 + WC;
    localparam int WAIT_BUSY = WC;
`else
    localparam int WAIT_CYC  = 3;
    localparam int WAIT_BUSY = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   mem_rdata;
    logic          mem_ready;
    logic [4:0]    alu_flags;
    logic [PW-1:0] reg_b;
    logic [PW-1:0] pc;
    logic          mem_addr_sel, mem_we, reg_we, wb_sel, alu_op_sel, busy_wait;
    logic [15:0]   alu_override;
    logic [3:0]    reg_waddr, reg_raddr_a, reg_raddr_b;
    logic [4:0]    saved_flags;

    always #5 clk = ~clk;

    control_fsm #(
        .PC_WIDTH    (PW),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .alu_flags    (alu_flags),
        .reg_b        (reg_b),
        .pc           (pc),
        .mem_addr_sel (mem_addr_sel),
        .mem_we       (mem_we),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .alu_op_sel   (alu_op_sel),
        .alu_override (alu_override),
        .reg_waddr    (reg_waddr),
        .reg_raddr_a  (reg_raddr_a),
        .reg_raddr_b  (reg_raddr_b),
        .saved_flags  (saved_flags),
        .busy_wait    (busy_wait)
    );

    typedef struct {
        string         name;
        logic [15:0]   instr;
        logic [4:0]    flags;
        logic [PW-1:0] rb;
        int            stall_f;
        int            stall_l;
        int            cycles;
        int            n_reg_we;
        int            n_mem_we;
        int            n_busy;
        logic [PW-1:0] exp_pc;
        logic [4:0]    exp_saved;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [15:0] i, input logic [4:0] f,
                                input logic [PW-1:0] rb, input int sf, input int sl,
                                input int cyc, input int rwe, input int mwe, input int bsy,
                                input logic [PW-1:0] epc, input logic [4:0] esv);
        vec_t v;
        v.name = n; v.instr = i; v.flags = f; v.rb = rb;
        v.stall_f = sf; v.stall_l = sl; v.cycles = cyc;
        v.n_reg_we = rwe; v.n_mem_we = mwe; v.n_busy = bsy;
        v.exp_pc = epc; v.exp_saved = esv;
        return v;
    endfunction

    // Entered and left at a falling edge with the FSM in FETCH
    task automatic run_vec(input vec_t v);
        int            n_rwe = 0;
        int            n_mwe = 0;
        int            n_bsy = 0;
        logic [PW-1:0] pc0;
        pc0       = pc;
        mem_rdata = v.instr;
        alu_flags = v.flags;
        reg_b     = v.rb;
        for (int c = 0; c < v.cycles; c++) begin
            mem_ready = !((c < v.stall_f) ||
                          (c >= v.stall_f + 2 && c < v.stall_f + 2 + v.stall_l));
            #1;
            if (c == 0) check({v.name, " fetch addr_sel"}, 32'(mem_addr_sel), 32'd1);
            if (c == v.stall_f + 1) begin
                check({v.name, " raddr_a"}, 32'(reg_raddr_a), 32'(v.instr[11:8]));
                check({v.name, " raddr_b"}, 32'(reg_raddr_b), 32'(v.instr[3:0]));
            end
            if (v.stall_l > 0 && c >= v.stall_f + 2 && c < v.stall_f + 2 + v.stall_l)
                check({v.name, " load1 addr_sel"}, 32'(mem_addr_sel), 32'd0);
            if (reg_we) begin
                n_rwe++;
                check({v.name, " wb_sel"}, 32'(wb_sel), 32'(v.instr[15:12] != 4'h6));
                check({v.name, " waddr"}, 32'(reg_waddr), 32'(v.instr[11:8]));
            end
            if (mem_we) begin
                n_mwe++;
                check({v.name, " override"}, 32'(alu_override), {16'h0, 4'h5, v.instr[11:8], 8'h00});
                check({v.name, " store addr_sel"}, 32'(mem_addr_sel), 32'd0);
                check({v.name, " alu_op_sel"}, 32'(alu_op_sel), 32'd0);
            end
            if (busy_wait) n_bsy++;
            if (c == v.cycles - 1) check({v.name, " pc before last edge"}, 32'(pc), 32'(pc0));
            @(negedge clk);
        end
        check({v.name, " reg_we count"}, n_rwe, v.n_reg_we);
        check({v.name, " mem_we count"}, n_mwe, v.n_mem_we);
        check({v.name, " busy count"}, n_bsy, v.n_busy);
        check({v.name, " pc"}, 32'(pc), 32'(v.exp_pc));
        check({v.name, " saved_flags"}, 32'(saved_flags), 32'(v.exp_saved));
    endtask

    task automatic check_idle(input string name);
        #1;
        check({name, " pc"}, 32'(pc), 32'd0);
        check({name, " saved_flags"}, 32'(saved_flags), 32'd0);
        check({name, " busy_wait"}, 32'(busy_wait), 32'd0);
        check({name, " addr_sel"}, 32'(mem_addr_sel), 32'd1);
        check({name, " strobes"}, {30'd0, reg_we, mem_we}, 32'd0);
        check({name, " alu_sel/wb/override"}, {15'd0, alu_op_sel, wb_sel, alu_override},
              {15'd0, 2'b11, 16'h0});
    endtask

    initial begin
        vec_t vecs[$];
        logic [4:0] ff;
        ff        = 5'b11111;
        reset     = 1'b1;
        mem_rdata = 16'h0;
        mem_ready = 1'b0;
        alu_flags = 5'h0;
        reg_b     = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_idle("reset");

        vecs.push_back(mk("rtype", 16'h0512, 5'b01000, 0, 0, 0, 3, 1, 0, 0, 15'd1, 5'b01000));
        vecs.push_back(mk("juc10", 16'h4E03, ff, 15'd10, 0, 0, 3, 0, 0, 0, 15'd10, 5'b01000));
        vecs.push_back(mk("beq_taken", 16'hC0FE, ff, 0, 0, 0, 3, 0, 0, 0, 15'd8, 5'b01000));
        vecs.push_back(mk("rtype_clrz", 16'h0512, 5'b00000, 0, 0, 0, 3, 1, 0, 0, 15'd9, 5'b0));
        vecs.push_back(mk("juc10b", 16'h4E03, ff, 15'd10, 0, 0, 3, 0, 0, 0, 15'd10, 5'b0));
        vecs.push_back(mk("beq_not", 16'hC0FE, ff, 0, 0, 0, 3, 0, 0, 0, 15'd11, 5'b0));
        vecs.push_back(mk("juc1234", 16'h4E03, ff, 15'h1234, 0, 0, 3, 0, 0, 0, 15'h1234, 5'b0));
        vecs.push_back(mk("load_stall", 16'h6307, ff, 15'h40, 0, 2, 6, 1, 0, 0, 15'h1235, 5'b0));
        vecs.push_back(mk("load_fstall", 16'h6307, ff, 15'h40, 1, 0, 5, 1, 0, 0, 15'h1236, 5'b0));
        vecs.push_back(mk("store", 16'h7205, ff, 15'h41, 0, 0, 3, 0, 1, 0, 15'h1237, 5'b0));
        vecs.push_back(mk("wait", 16'hF000, ff, 0, 0, 0, WAIT_CYC, 0, 0, WAIT_BUSY,
                          15'h1238, 5'b0));
        vecs.push_back(mk("rtype_c", 16'h0123, 5'b00001, 0, 0, 0, 3, 1, 0, 0, 15'h1239, 5'b00001));
        vecs.push_back(mk("bcs", 16'hC205, ff, 0, 0, 0, 3, 0, 0, 0, 15'h123E, 5'b00001));
        vecs.push_back(mk("bcc", 16'hC3F0, ff, 0, 0, 0, 3, 0, 0, 0, 15'h123F, 5'b00001));
        vecs.push_back(mk("bnever", 16'hCA10, ff, 0, 0, 0, 3, 0, 0, 0, 15'h1240, 5'b00001));
        vecs.push_back(mk("jeq_not", 16'h4010, ff, 15'h55, 0, 0, 3, 0, 0, 0, 15'h1241, 5'b00001));
        vecs.push_back(mk("juc_top", 16'h4E03, ff, 15'h7FFF, 0, 0, 3, 0, 0, 0, 15'h7FFF, 5'b00001));
        vecs.push_back(mk("rtype_wrap", 16'h0000, 5'b10000, 0, 0, 0, 3, 1, 0, 0, 15'h0, 5'b10000));
        vecs.push_back(mk("buc_back", 16'hCEFF, ff, 0, 0, 0, 3, 0, 0, 0, 15'h7FFF, 5'b10000));
        vecs.push_back(mk("bgt_wrap", 16'hC602, ff, 0, 0, 0, 3, 0, 0, 0, 15'h0001, 5'b10000));

        foreach (vecs[k]) run_vec(vecs[k]);

`ifdef CONTROL_WAIT_EN
        // Reset partway through a WAIT, then a full WAIT must still take WC cycles
        mem_rdata = 16'hF000;
        mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("midwait busy", 32'(busy_wait), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("midwait reset");
        run_vec(mk("wait_after_rst", 16'hF000, ff, 0, 0, 0, WAIT_CYC, 0, 0, WAIT_BUSY,
                   15'h1, 5'b0));
`else
        run_vec(mk("wait_nop2", 16'hF000, ff, 0, 0, 0, WAIT_CYC, 0, 0, WAIT_BUSY,
                   15'h2, 5'b10000));
`endif

        // Reset while LOAD1 is stalled on mem_ready
        mem_rdata = 16'h6307;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("load1 stall addr_sel", 32'(mem_addr_sel), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("load1 reset");
        run_vec(mk("rtype_after_rst", 16'h0512, 5'b01000, 0, 0, 0, 3, 1, 0, 0, 15'd1, 5'b01000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Parametrised multicycle control unit for the 16-bit datapath: fetches an instruction through memory port A, latches it into an internal instruction register, and sequences register-file, ALU-override, memory and PC controls for R/I-type, load, store, conditional branch/jump and timed-wait instructions. It sits between Memory, Register_File and ALU. Compared with the existing controller it adds a latched IR, a memory-ready handshake, conditional control flow, a registered wait timer and configurable PC width and wait length.

## Interface
- PC_WIDTH, 15: width of PC and of memory port A address.
- WAIT_CYCLES, 166666: length of a WAIT instruction in clock cycles; must be at least 1.
- WAIT_CNT_WIDTH, $clog2(WAIT_CYCLES+1): width of the wait counter.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_rdata  in  16  memory port A read data.
- mem_ready  in  1  port A read data valid this cycle.
- alu_flags  in  5  ALU flags {N,Z,F,L,C}; bit 0 is C.
- reg_b  in  PC_WIDTH  register-file port B value, low bits; used as load/store address and jump target.
- pc  out  PC_WIDTH  program counter (registered).
- mem_addr_sel  out  1  1 = PC drives port A address, 0 = reg_b.
- mem_we  out  1  port A write strobe.
- reg_we  out  1  register-file write enable.
- wb_sel  out  1  1 = ALU result, 0 = memory data to register file.
- alu_op_sel  out  1  1 = ALU opcode from IR, 0 = alu_override.
- alu_override  out  16  ALU opcode used when alu_op_sel = 0.
- reg_waddr, reg_raddr_a, reg_raddr_b  out  4 each  IR[11:8], IR[11:8], IR[3:0].
- saved_flags  out  5  flags latched by the last R/I-type instruction; bit 0 feeds ALU carry_in.
- busy_wait  out  1  high while in WAIT.

## Operation
- States: FETCH, DECODE, EXEC, BRANCH, LOAD1, LOAD2, STORE, WAIT.
- FETCH: mem_addr_sel = 1. Stays in FETCH while mem_ready = 0. When mem_ready = 1, ir <= mem_rdata and the FSM moves to DECODE.
- DECODE: dispatches on ir[15:12]:
  - OP_BCOND / OP_JCOND -> BRANCH
  - OP_LOAD -> LOAD1
  - OP_STORE -> STORE
  - OP_WAIT -> WAIT
  - all other opcodes -> EXEC
- EXEC: reg_we = 1, wb_sel = 1, alu_op_sel = 1. saved_flags <= alu_flags. pc <= pc+1.
- BRANCH: the condition ir[11:8] is evaluated on saved_flags.
  - Condition false: pc <= pc+1.
  - OP_BCOND, condition true: pc <= pc + sign-extended ir[7:0].
  - OP_JCOND, condition true: pc <= reg_b.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - 14 UC: always true
  - all other codes: never true
- LOAD1: mem_addr_sel = 0. Holds while mem_ready = 0; moves to LOAD2 when mem_ready = 1.
- LOAD2: mem_addr_sel = 0, reg_we = 1, wb_sel = 0. pc <= pc+1.
- STORE: mem_addr_sel = 0, mem_we = 1, alu_op_sel = 0. alu_override = {OP_ADDI, ir[11:8], 8'h00}, so the ALU passes reg_a through. pc <= pc+1.
- WAIT: the counter increments each cycle. When it equals WAIT_CYCLES-1: counter <= 0, pc <= pc+1, next state FETCH.
- Every non-fetch state returns to FETCH, except LOAD1 -> LOAD2 and WAIT while counting.
- Flags are saved only in EXEC. Branches, loads, stores and waits leave saved_flags unchanged.
- PC arithmetic wraps modulo 2^PC_WIDTH.

## Timing
- Reset values: state FETCH, pc 0, ir 0, saved_flags 0, wait counter 0. Reset overrides every state, including mid-WAIT and a stalled LOAD1.
- pc, ir, saved_flags and the wait counter are registered. All other outputs decode combinationally from state and ir.
- Outputs in FETCH and DECODE: all strobes 0, mem_addr_sel 1, alu_op_sel 1, wb_sel 1, alu_override 0.
- Cycles per instruction with mem_ready always high:
  - R/I-type: 3
  - branch/jump: 3
  - store: 3
  - load: 4
  - wait: 2 + WAIT_CYCLES
- Each cycle with mem_ready low in FETCH or LOAD1 adds one cycle.
- ir is stable from DECODE until the next FETCH completes, so reg_waddr stays valid in LOAD2.

## Configuration
- CONTROL_WAIT_EN defined: WAIT behaves as above.
- CONTROL_WAIT_EN undefined: the counter and the WAIT state are removed. OP_WAIT dispatches to EXEC with reg_we forced to 0 and flags not saved, i.e. a 3-cycle NOP. busy_wait is tied to 0.

## Structure
- Shared package control_pkg holds:
  - state encoding
  - opcodes OP_BCOND=4'hC, OP_JCOND=4'h4, OP_LOAD=4'h6, OP_STORE=4'h7, OP_WAIT=4'hF, OP_ADDI=4'h5
  - condition-code constants
  - flag bit indices
- One sub-module, cond_check: combinational; takes saved_flags and a 4-bit condition code and returns taken.

## Test plan
- Reset mid-WAIT (counter at 100) -> next cycle: state FETCH, pc 0, saved_flags 0, busy_wait 0.
- R-type 16'h0512 with mem_ready = 1 and alu_flags = 5'b01000 -> reg_we high exactly one cycle (cycle 3); saved_flags = 5'b01000; pc 0 -> 1.
- BEQ (16'hC0FE) at pc 10 with Z = 1 -> pc 8; same instruction with Z = 0 -> pc 11; JUC 16'h4E03 with reg_b = 0x1234 -> pc 0x1234.
- LOAD 16'h6307 with mem_ready low for 2 cycles in LOAD1 -> 6 cycles total; reg_we with wb_sel = 0 and reg_waddr = 3 in the last cycle.
- STORE 16'h7205 -> alu_override = 16'h5200, mem_we high for 1 cycle, mem_addr_sel = 0.
- WAIT with WAIT_CYCLES = 4 -> busy_wait high for 4 cycles, then pc+1; with CONTROL_WAIT_EN undefined -> 3-cycle NOP.
